song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised song player front end that walks a synchronous song ROM one entry at a time and presents each note to the note player for that entry's duration. It supports multiple songs stored as equal-sized segments of one ROM. It sits between the song ROM (1-cycle registered read) and the note player / beat generator. Each entry's note code is held for its duration in beats, then the next entry is fetched.

## Interface
- `ADDR_W`, default 7: ROM address width. Depth is 2^ADDR_W entries.
- `NUM_SONGS`, default 2: number of songs, power of two, at most 2^ADDR_W. Segment length is `SEG = 2^ADDR_W / NUM_SONGS`.
- `SEL_W`, default 1: song select width, equal to log2(`NUM_SONGS`), minimum 1.
- `NOTE_W`, default 6: note code width.
- `DUR_W`, default 6: duration width, in beats.
- `DATA_W`, default 16: ROM word width. Layout: note is at `[DATA_W-2 -: NOTE_W]` and duration is immediately below it. The MSB and the low bits are ignored.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `play` in 1: level. High runs the song; low aborts to idle.
- `song_sel` in `SEL_W`: song index. Sampled only on leaving IDLE.
- `beat` in 1: one-cycle tick from the beat generator.
- `rom_addr` out `ADDR_W`: registered ROM address.
- `rom_data` in `DATA_W`: ROM output. Valid one cycle after `rom_addr` is presented.
- `note` out `NOTE_W`: current note code. 0 means rest or silence.
- `new_note` out 1: one-cycle pulse when `note` is loaded from a new entry.
- `busy` out 1: high in every state except IDLE.
- `song_done` out 1: one-cycle pulse at end of song.

## Operation
- Reset values: state IDLE, `rom_addr`=0, `note`=0, `new_note`=0, `busy`=0, `song_done`=0, beat counter 0.
- IDLE, when `play`=1:
  - latch `base = song_sel*SEG`;
  - `rom_addr <= base`;
  - go to FETCH.
- FETCH (1 cycle): the ROM registers `rom_addr`. Go to LOAD.
- LOAD (1 cycle): decode `rom_data`.
  - Duration 0 is the end marker. Pulse `song_done`, set `note <= 0`, go to END.
  - Otherwise:
    - `note <= entry note`;
    - `new_note <= 1`;
    - `cnt <= duration`;
    - go to HOLD.
- HOLD: on each `beat`, `cnt` decrements. On the `beat` where `cnt`=1, advance:
  - If `rom_addr` is the last address of the segment (`base+SEG-1`), treat it as end of song. This applies exactly as for the end marker and is not a fetch.
  - Otherwise `rom_addr <= rom_addr+1` and go to FETCH. The segment never wraps into the next song.
- END, without loop: stay in END with `note`=0 and `busy`=1 until `play`=0, then go to IDLE.
- `play`=0 in any non-IDLE state: next state is IDLE, `note <= 0`, `rom_addr` is held. This has priority over every other transition, including a coincident `beat` or end condition. No `song_done` is generated on abort.
- A rest entry (note 0, duration ≠ 0) is played like any other note: `new_note` pulses and `note`=0.
- `song_sel` changes while busy are ignored until the next start from IDLE.
- `beat` in FETCH or LOAD is dropped. It is not counted toward the next entry.

## Timing
- From `play` rising while in IDLE: `rom_addr` is valid after edge 1, the ROM data is captured at edge 2, and `note`/`new_note` are valid after edge 3. Latency is 3 cycles.
- Inter-note gap: 2 cycles (FETCH, LOAD) after the final beat. During the gap `note` keeps the old value, so the note player sees a glitch-free change.
- `new_note` and `song_done` are registered pulses, exactly 1 cycle wide, and never asserted together.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Asynchronous reset mid-song returns all outputs to their reset values immediately. The ROM contents are irrelevant to reset.

## Configuration
- `SONG_LOOP_EN` defined: at end of song (end marker or segment end), pulse `song_done` and then set `rom_addr <= base` and go to FETCH. The END state is never entered, and the song repeats for as long as `play` stays high. The restart latency from the end condition to the first `new_note` equals the inter-note gap plus the LOAD cycle of the end marker.
- `SONG_LOOP_EN` undefined: one-shot behaviour as in Operation. The song stops in END and `note` stays 0.

## Test plan
- Reset and start: while `reset_n`=0, all outputs are 0. With `song_sel`=1, raise `play`: `rom_addr`=64 after 1 edge, and `new_note` pulses on the 3rd edge with `note` equal to the entry-64 note.
- Duration count: entry {note 37, dur 3} followed by {note 30, dur 2}, with `beat` every 10 cycles. `note`=37 is held through exactly 3 beats, then `rom_addr` increments and `note`=30 appears 2 cycles after the 3rd beat.
- End marker, no loop: the third entry has duration 0. `song_done` pulses once, `note`=0, and `busy` stays 1. Dropping `play` returns to IDLE with `busy`=0 on the next edge.
- Segment end: song 0 with all 64 entries nonzero. After entry 63, end of song occurs, and `rom_addr` never reaches 64.
- Abort: drop `play` in the same cycle as the final `beat` of a note. The next state is IDLE and `note`=0, with no fetch and no `song_done`. Also assert `reset_n` low mid-HOLD and check that outputs clear asynchronously.
- With `SONG_LOOP_EN`: on the end marker, `song_done` pulses, `rom_addr` returns to base, and the first entry's `note` re-appears with `new_note`. Repeat for 3 loops.

Source files
------------

// File: rtl/song_sequencer.sv
// Song ROM walker: fetches one entry at a time, holds its note for its duration in beats.
// Optional SONG_LOOP_EN: restart the selected song at end instead of stopping in END.
module song_sequencer #(
  parameter int ADDR_W    = 7,
  parameter int NUM_SONGS = 2,
  parameter int SEL_W     = 1,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note,
  output logic              new_note,
  output logic              busy,
  output logic              song_done
);

  localparam int SEG_LOG2 = ADDR_W - $clog2(NUM_SONGS);
  localparam logic [ADDR_W-1:0] SEG_MASK = ADDR_W'((1 << SEG_LOG2) - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_END} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [DUR_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] rom_addr_next;
  logic [NOTE_W-1:0] note_next;
  logic              new_note_next, song_done_next, busy_next;
  logic              end_song;

  logic [NOTE_W-1:0] entry_note;
  logic [DUR_W-1:0]  entry_dur;
  logic [ADDR_W-1:0] sel_base;
  logic [ADDR_W-1:0] seg_last;
  logic              unused_rom_parity;

  assign entry_note = rom_data[DATA_W-2 -: NOTE_W];
  assign entry_dur  = rom_data[DATA_W-2-NOTE_W -: DUR_W];
  // Segments are power-of-two aligned, so the last address is the base with the low bits set.
  assign sel_base   = ADDR_W'(song_sel) << SEG_LOG2;
  assign seg_last   = base_reg | SEG_MASK;
  assign unused_rom_parity = ^rom_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      base_reg  <= '0;
      cnt_reg   <= '0;
      rom_addr  <= '0;
      note      <= '0;
      new_note  <= 1'b0;
      busy      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      cnt_reg   <= cnt_next;
      rom_addr  <= rom_addr_next;
      note      <= note_next;
      new_note  <= new_note_next;
      busy      <= busy_next;
      song_done <= song_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    cnt_next       = cnt_reg;
    rom_addr_next  = rom_addr;
    note_next      = note;
    new_note_next  = 1'b0;
    song_done_next = 1'b0;
    end_song       = 1'b0;

    // Dropping play aborts from anywhere, ahead of beats and end conditions.
    if (state_reg != S_IDLE && !play) begin
      state_next = S_IDLE;
      note_next  = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (play) begin
            base_next     = sel_base;
            rom_addr_next = sel_base;
            state_next    = S_FETCH;
          end
        end
        S_FETCH: state_next = S_LOAD;
        S_LOAD: begin
          if (entry_dur == '0) begin
            end_song = 1'b1;
          end else begin
            note_next     = entry_note;
            new_note_next = 1'b1;
            cnt_next      = entry_dur;
            state_next    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (beat) begin
            if (cnt_reg == DUR_W'(1)) begin
              if (rom_addr == seg_last) begin
                end_song = 1'b1;
              end else begin
                rom_addr_next = rom_addr + ADDR_W'(1);
                state_next    = S_FETCH;
              end
            end else begin
              cnt_next = cnt_reg - DUR_W'(1);
            end
          end
        end
        S_END: state_next = S_END;
        default: state_next = S_IDLE;
      endcase

      if (end_song) begin
        song_done_next = 1'b1;
        note_next      = '0;
`ifdef SONG_LOOP_EN
        rom_addr_next  = base_reg;
        state_next     = S_FETCH;
`else
        state_next     = S_END;
`endif
      end
    end

    busy_next = (state_next != S_IDLE);
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: start latency, duration counting, rest/end marker,
// segment end, abort and asynchronous reset (loop variant when SONG_LOOP_EN is defined).
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic [0:0]  song_sel;
  logic        beat;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [5:0]  note;
  logic        new_note;
  logic        busy;
  logic        song_done;

  logic [15:0] rom_mem [0:127];
  int total = 0;
  int bad = 0;
  logic seg_watch = 1'b0;

  song_sequencer dut (
    .clk(clk), .reset_n(reset_n), .play(play), .song_sel(song_sel), .beat(beat),
    .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .new_note(new_note),
    .busy(busy), .song_done(song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [15:0] mk(input int n, input int d);
    return {1'b0, 6'(n), 6'(d), 3'b000};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic give_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) cyc();
      beat = 1'b1;
      cyc();
      beat = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      total++;
      if (new_note && song_done) begin
        bad++;
        $display("FAIL pulse_overlap: new_note=%0b song_done=%0b required not both", new_note, song_done);
      end
    end
    if (seg_watch) begin
      total++;
      if (rom_addr >= 7'd64) begin
        bad++;
        $display("FAIL seg_bound: rom_addr=%0d required <64", rom_addr);
      end
    end
  end

  task automatic test_reset();
    #2;
    total++; if ({rom_addr, note, new_note, busy, song_done} !== '0) begin bad++; $display("FAIL reset_outputs: addr=%0d note=%0d nn=%0b busy=%0b done=%0b required 0", rom_addr, note, new_note, busy, song_done); end
    repeat (2) cyc();
    total++; if ({rom_addr, note, new_note, busy, song_done} !== '0) begin bad++; $display("FAIL reset_held: addr=%0d note=%0d busy=%0b required 0", rom_addr, note, busy); end
    reset_n = 1'b1;
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b required 0", busy); end
  endtask

  task automatic test_start();
    song_sel = 1'b1;
    play = 1'b1;
    cyc();
    total++; if (rom_addr !== 7'd64) begin bad++; $display("FAIL start_addr: got %0d required 64", rom_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %0b required 1", busy); end
    song_sel = 1'b0;
    cyc();
    total++; if (new_note !== 1'b0) begin bad++; $display("FAIL start_early_nn: got %0b required 0", new_note); end
    cyc();
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL start_nn: got %0b required 1", new_note); end
    total++; if (note !== 6'd37) begin bad++; $display("FAIL start_note: got %0d required 37", note); end
  endtask

  task automatic test_duration();
    for (int b = 0; b < 3; b++) begin
      repeat (9) cyc();
      beat = 1'b1;
      cyc();
      if (b < 2) begin
        beat = 1'b0;
        total++; if (note !== 6'd37 || rom_addr !== 7'd64) begin bad++; $display("FAIL hold_note: note=%0d addr=%0d required 37/64", note, rom_addr); end
      end
    end
    // beat stays high through FETCH and LOAD: must be dropped
    total++; if (rom_addr !== 7'd65 || note !== 6'd37) begin bad++; $display("FAIL advance: addr=%0d note=%0d required 65/37", rom_addr, note); end
    cyc();
    total++; if (note !== 6'd37 || new_note !== 1'b0) begin bad++; $display("FAIL gap_note: note=%0d nn=%0b required 37/0", note, new_note); end
    cyc();
    beat = 1'b0;
    total++; if (note !== 6'd30 || new_note !== 1'b1) begin bad++; $display("FAIL second_note: note=%0d nn=%0b required 30/1", note, new_note); end
    cyc();
    total++; if (new_note !== 1'b0) begin bad++; $display("FAIL nn_width: got %0b required 0", new_note); end
    give_beats(1, 10);
    total++; if (rom_addr !== 7'd65 || note !== 6'd30) begin bad++; $display("FAIL dur2_first: addr=%0d note=%0d required 65/30", rom_addr, note); end
    give_beats(1, 10);
    total++; if (rom_addr !== 7'd66) begin bad++; $display("FAIL dur2_advance: got %0d required 66", rom_addr); end
  endtask

  task automatic test_end();
    cyc();
    cyc();
    total++; if (new_note !== 1'b1 || note !== 6'd0) begin bad++; $display("FAIL rest_entry: nn=%0b note=%0d required 1/0", new_note, note); end
    give_beats(1, 4);
    cyc();
    cyc();
    total++; if (song_done !== 1'b1 || note !== 6'd0 || busy !== 1'b1) begin bad++; $display("FAIL end_marker: done=%0b note=%0d busy=%0b required 1/0/1", song_done, note, busy); end
`ifdef SONG_LOOP_EN
    total++; if (rom_addr !== 7'd64) begin bad++; $display("FAIL loop_addr: got %0d required 64", rom_addr); end
    for (int l = 0; l < 3; l++) begin
      cyc();
      cyc();
      total++; if (new_note !== 1'b1 || note !== 6'd37 || rom_addr !== 7'd64) begin bad++; $display("FAIL loop_first: nn=%0b note=%0d addr=%0d required 1/37/64", new_note, note, rom_addr); end
      give_beats(3, 3);
      cyc();
      cyc();
      total++; if (note !== 6'd30) begin bad++; $display("FAIL loop_second: got %0d required 30", note); end
      give_beats(2, 3);
      cyc();
      cyc();
      give_beats(1, 3);
      cyc();
      cyc();
      total++; if (song_done !== 1'b1 || rom_addr !== 7'd64) begin bad++; $display("FAIL loop_done: done=%0b addr=%0d required 1/64", song_done, rom_addr); end
    end
`else
    total++; if (rom_addr !== 7'd67) begin bad++; $display("FAIL end_addr: got %0d required 67", rom_addr); end
    cyc();
    total++; if (song_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL end_hold: done=%0b busy=%0b required 0/1", song_done, busy); end
    give_beats(2, 3);
    total++; if (note !== 6'd0 || new_note !== 1'b0 || rom_addr !== 7'd67) begin bad++; $display("FAIL end_stay: note=%0d nn=%0b addr=%0d required 0/0/67", note, new_note, rom_addr); end
`endif
    play = 1'b0;
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %0b required 0", busy); end
  endtask

  task automatic test_segment_end();
    song_sel = 1'b0;
    play = 1'b1;
    repeat (3) cyc();
    total++; if (note !== 6'd1 || new_note !== 1'b1) begin bad++; $display("FAIL seg_first: note=%0d nn=%0b required 1/1", note, new_note); end
    seg_watch = 1'b1;
    for (int k = 0; k < 63; k++) begin
      give_beats(1, 2);
      cyc();
      cyc();
      total++; if (note !== 6'(((k + 1) % 63) + 1) || rom_addr !== 7'(k + 1)) begin bad++; $display("FAIL seg_entry: note=%0d addr=%0d required %0d/%0d", note, rom_addr, ((k + 1) % 63) + 1, k + 1); end
    end
    give_beats(1, 2);
    total++; if (song_done !== 1'b1 || note !== 6'd0) begin bad++; $display("FAIL seg_done: done=%0b note=%0d required 1/0", song_done, note); end
`ifdef SONG_LOOP_EN
    total++; if (rom_addr !== 7'd0) begin bad++; $display("FAIL seg_loop_addr: got %0d required 0", rom_addr); end
`else
    total++; if (rom_addr !== 7'd63) begin bad++; $display("FAIL seg_end_addr: got %0d required 63", rom_addr); end
`endif
    repeat (5) cyc();
    seg_watch = 1'b0;
    play = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    song_sel = 1'b1;
    play = 1'b1;
    repeat (3) cyc();
    give_beats(2, 3);
    repeat (2) cyc();
    beat = 1'b1;
    play = 1'b0;
    cyc();
    beat = 1'b0;
    total++; if (busy !== 1'b0 || note !== 6'd0) begin bad++; $display("FAIL abort_idle: busy=%0b note=%0d required 0/0", busy, note); end
    total++; if (song_done !== 1'b0 || rom_addr !== 7'd64) begin bad++; $display("FAIL abort_nofetch: done=%0b addr=%0d required 0/64", song_done, rom_addr); end
    cyc();
    total++; if (rom_addr !== 7'd64 || new_note !== 1'b0 || song_done !== 1'b0) begin bad++; $display("FAIL abort_after: addr=%0d nn=%0b done=%0b required 64/0/0", rom_addr, new_note, song_done); end
  endtask

  task automatic test_async_reset();
    play = 1'b1;
    repeat (3) cyc();
    total++; if (note !== 6'd37) begin bad++; $display("FAIL rst_pre_note: got %0d required 37", note); end
    cyc();
    #2 reset_n = 1'b0;
    #1;
    total++; if ({rom_addr, note, new_note, busy, song_done} !== '0) begin bad++; $display("FAIL async_reset: addr=%0d note=%0d busy=%0b required 0", rom_addr, note, busy); end
    @(negedge clk);
    play = 1'b0;
    reset_n = 1'b1;
    cyc();
    total++; if (busy !== 1'b0 || rom_addr !== 7'd0) begin bad++; $display("FAIL post_reset: busy=%0b addr=%0d required 0/0", busy, rom_addr); end
  endtask

  initial begin
    reset_n = 1'b0;
    play = 1'b0;
    beat = 1'b0;
    song_sel = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = mk((i % 63) + 1, 1);
    for (int i = 64; i < 128; i++) rom_mem[i] = mk(0, 0);
    rom_mem[64] = mk(37, 3);
    rom_mem[65] = mk(30, 2);
    rom_mem[66] = mk(0, 1);
    rom_mem[67] = mk(5, 0);

    test_reset();
    test_start();
    test_duration();
    test_end();
    test_segment_end();
    test_abort();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
